// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 7-segment display arbiter.
//   state_t   : arbiter FSM states (IDLE, SHOW, GAP)
//   HEX_SEG   : hex digit to segment code, bits [6:0] = gfedcba, active-high
//   SEG_BLANK : all segments and decimal point off
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex nibble to 7-segment decoder.
//   nibble : 4-bit hex digit
//   seg    : segment code gfedcba, active-high
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_share_arbiter.sv
// seg_share_arbiter: round-robin owner selection for the single 7-segment
// display. Each grantee owns the display for up to DWELL_CYCLES cycles (less
// if it drops its request), followed by one blank GAP cycle.
//   clk_2 : system clock, all state changes on posedge
//   reset : synchronous, active-high
//   req   : level request per requester
//   data  : hex nibble per requester, requester i on data[4*i+3:4*i]
//   SEG   : registered segment drive, [6:0]=gfedcba, [7]=decimal point
//   grant : registered one-hot grant, zero when nobody owns the display
//   busy  : registered, high while a requester is being shown
// Optional build macro SEG_BLINK_EN: blinks the decimal point while IDLE,
// toggling every BLINK_CYCLES cycles. Without it the display is blank in IDLE.
module seg_share_arbiter
  import seg_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DWELL_CYCLES = 4,
  parameter int BLINK_CYCLES = 8
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] data,
  output logic [7:0]        SEG,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int PTR_W = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = ($clog2(DWELL_CYCLES) > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  if (NREQ < 2 || NREQ > 8 || DWELL_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_param
    $error("seg_share_arbiter: parameter out of range");
  end

  state_t             state, state_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [PTR_W-1:0]   owner, owner_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NREQ-1:0]    grant_n;
  logic               busy_n;
  logic [7:0]         seg_n;

  logic               sel_vld;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   mux_idx;
  logic [3:0]         show_nib;
  logic [6:0]         seg_code;
  logic               release_now;

`ifdef SEG_BLINK_EN
  localparam int BLK_W = ($clog2(BLINK_CYCLES) > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);
  logic [BLK_W-1:0]   blk_cnt, blk_cnt_n;
  logic               blink, blink_n;
`endif

  // Search from the highest offset down so the lowest offset from ptr wins.
  always_comb begin : arb
    int idx;
    sel_vld = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        sel_vld = 1'b1;
        sel_idx = PTR_W'(idx);
      end
    end
  end

  // One decoder serves both the incoming owner (at grant) and the current one.
  assign mux_idx  = (state == SHOW) ? owner : sel_idx;
  assign show_nib = data[int'(mux_idx)*4 +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (show_nib),
    .seg    (seg_code)
  );

  assign release_now = (cnt == CNT_LAST) || !req[owner];

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    owner_n   = owner;
    cnt_n     = cnt;
    grant_n   = grant;
    busy_n    = busy;
    seg_n     = SEG;
`ifdef SEG_BLINK_EN
    blk_cnt_n = '0;
    blink_n   = 1'b0;
`endif
    case (state)
      IDLE, GAP: begin
        if (sel_vld) begin
          state_n = SHOW;
          owner_n = sel_idx;
          grant_n = NREQ'(1) << sel_idx;
          busy_n  = 1'b1;
          cnt_n   = '0;
          seg_n   = {1'b0, seg_code};
        end else begin
          state_n = IDLE;
          grant_n = '0;
          busy_n  = 1'b0;
          seg_n   = SEG_BLANK;
`ifdef SEG_BLINK_EN
          // Blink only while already idle; entry from GAP restarts at zero.
          if (state == IDLE) begin
            if (blk_cnt == BLK_LAST) begin
              blk_cnt_n = '0;
              blink_n   = ~blink;
            end else begin
              blk_cnt_n = blk_cnt + BLK_W'(1);
              blink_n   = blink;
            end
            seg_n = {blink_n, 7'b0};
          end
`endif
        end
      end
      SHOW: begin
        if (release_now) begin
          state_n = GAP;
          grant_n = '0;
          busy_n  = 1'b0;
          seg_n   = SEG_BLANK;
          cnt_n   = '0;
          ptr_n   = (owner == PTR_LAST) ? '0 : owner + PTR_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
          seg_n = {1'b0, seg_code};
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
        seg_n   = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      SEG     <= SEG_BLANK;
`ifdef SEG_BLINK_EN
      blk_cnt <= '0;
      blink   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      cnt     <= cnt_n;
      grant   <= grant_n;
      busy    <= busy_n;
      SEG     <= seg_n;
`ifdef SEG_BLINK_EN
      blk_cnt <= blk_cnt_n;
      blink   <= blink_n;
`endif
    end
  end

endmodule
